mac_loop_ctrl: RTL and testbench
================================

// Module: mac_loop_ctrl
// PURPOSE
//  Parametrised nested-loop iteration controller for the HWPE MAC engine; supersedes the 1-loop hardwired ucode path.
//  On start, walks N_LOOPS nested counters (loop 0 innermost) and emits one address-offset tuple per iteration for N_STREAMS streams.
//  Handshakes each tuple to the streamer with valid/ready, flags loop ends for accumulator control, pulses done at the end of the job.
//  Sits between the controller FSM / register file and the streamer/engine.
// PARAMETERS
//  N_LOOPS   = 3   number of nested loops (>=1)
//  N_STREAMS = 3   number of address offsets generated per iteration (>=1)
//  CNT_W     = 12  loop counter / range width
//  ADDR_W    = 32  offset width
// PORTS
//  clk_i          in   1                      clock
//  rst_ni         in   1                      async reset, active low
//  clear_i        in   1                      sync soft clear, same effect as reset
//  start_i        in   1                      job start pulse; sampled only in IDLE
//  range_i        in   [N_LOOPS][CNT_W]       per-loop range; loop k runs range_i[k]+1 iterations
//  base_i         in   [N_STREAMS][ADDR_W]    per-stream base offset
//  stride_i       in   [N_LOOPS][N_STREAMS][ADDR_W]  per-loop, per-stream stride, two's complement
//  offs_o         out  [N_STREAMS][ADDR_W]    current offset tuple
//  offs_valid_o   out  1                      offs_o valid
//  offs_ready_i   in   1                      streamer accepts tuple
//  loop_end_o     out  [N_LOOPS]              bit k: current tuple is the last iteration of loop k
//  busy_o         out  1                      high in RUN and DONE
//  done_o         out  1                      one-cycle pulse: job finished
// BEHAVIOUR
//  Reset/clear: state IDLE; all outputs 0; counters, offsets, snapshot regs 0. clear_i overrides all else, incl. mid-job.
//  States: IDLE -> RUN on start_i; RUN -> DONE on handshake of final tuple; DONE -> IDLE unconditionally next cycle.
//  IDLE: start_i=1 at cycle t snapshots range_i/base_i/stride_i, idx[k]=0, level offsets=base;
//   RUN at t+1 with offs_valid_o=1, offs_o=base_i. Config inputs ignored outside that snapshot cycle.
//  start_i in RUN or DONE: ignored (no queuing).
//  Handshake = offs_valid_o & offs_ready_i. Without handshake, offs_o/loop_end_o/offs_valid_o held stable.
//  On handshake: j = lowest loop with idx[j] != range[j]. Loops 0..j-1 wrap to 0, idx[j]++.
//   Per-level base lvl[j] += stride[j]; lvl[i]=lvl[j] for all i<j; offs_o = new lvl[0]. Result appears next cycle.
//   Offset of iteration = base + sum_k idx[k]*stride[k], mod 2^ADDR_W (wrap, no saturation).
//  loop_end_o[k] = offs_valid_o & (idx[i]==range[i] for all i<=k); combinational from registered state.
//  Final tuple: all idx at range. Its handshake at cycle t -> offs_valid_o=0, done_o=1 at t+1 (DONE), busy_o=0 at t+2.
//  Single-iteration job (all ranges 0): exactly one tuple, loop_end_o all ones.
//  offs_valid_o back-to-back: one tuple per cycle under continuous ready, no bubbles.
//  Total tuples per job = prod_k (range[k]+1).
// TESTING
//  T1 N_LOOPS=2,N_STREAMS=1, range={1,2}, base 0x100, stride{4,0x40}, ready=1 -> offs 0x100,0x104,0x140,0x144,0x180,0x184;
//     loop_end_o[0] on beats 2,4,6, loop_end_o[1] on beat 6; done_o one cycle after beat 6.
//  T2 T1 config with ready toggled randomly (50%) -> identical offset sequence; offs_o stable while valid&!ready.
//  T3 all ranges 0, base {0x10,0x20,0x30} -> single tuple {0x10,0x20,0x30}, loop_end_o=all ones, done_o 1 cycle after accept.
//  T4 clear_i asserted after beat 3 of T1 -> offs_valid_o,busy_o=0 next cycle; new start emits 0x100 first.
//  T5 base 0, inner stride 0xFFFFFFFC, range{2} -> 0x0,0xFFFFFFFC,0xFFFFFFF8 (mod-2^32 wrap).
//  T6 start_i and changed base/stride during RUN of T1 -> ignored; sequence unchanged; rst_ni low mid-job -> all outputs 0 immediately.

Source files
------------

// File: rtl/mac_loop_ctrl.sv
// mac_loop_ctrl: nested-loop iteration controller for the HWPE MAC engine.
// Ports: clk_i/rst_ni/clear_i, start_i + range/base/stride config,
//   offs_o/offs_valid_o/offs_ready_i tuple handshake, loop_end_o, busy_o, done_o.
module mac_loop_ctrl #(
  parameter int N_LOOPS   = 3,
  parameter int N_STREAMS = 3,
  parameter int CNT_W     = 12,
  parameter int ADDR_W    = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic start_i,
  input  logic [N_LOOPS-1:0][CNT_W-1:0] range_i,
  input  logic [N_STREAMS-1:0][ADDR_W-1:0] base_i,
  input  logic [N_LOOPS-1:0][N_STREAMS-1:0][ADDR_W-1:0] stride_i,
  output logic [N_STREAMS-1:0][ADDR_W-1:0] offs_o,
  output logic offs_valid_o,
  input  logic offs_ready_i,
  output logic [N_LOOPS-1:0] loop_end_o,
  output logic busy_o,
  output logic done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE = 1;

  typedef logic [N_STREAMS-1:0][ADDR_W-1:0] tuple_t;

  state_e state_q, state_d;
  logic [N_LOOPS-1:0][CNT_W-1:0] range_q, range_d;
  logic [N_LOOPS-1:0][CNT_W-1:0] idx_q, idx_d;
  logic [N_LOOPS-1:0][N_STREAMS-1:0][ADDR_W-1:0] stride_q, stride_d;
  logic [N_LOOPS-1:0][N_STREAMS-1:0][ADDR_W-1:0] lvl_q, lvl_d;

  logic [N_LOOPS-1:0] at_end;
  logic [N_LOOPS-1:0] sel;
  logic acc;
  logic prev;
  tuple_t nxt;
  logic hs;

  // at_end[k]: loops 0..k all sit on their last iteration.
  // sel marks the loop that increments; loops below it wrap.
  always_comb begin
    at_end = '0;
    sel    = '0;
    acc    = 1'b1;
    prev   = 1'b1;
    for (int k = 0; k < N_LOOPS; k++) begin
      acc       = acc & (idx_q[k] == range_q[k]);
      at_end[k] = acc;
      sel[k]    = prev & ~acc;
      prev      = acc;
    end
  end

  always_comb begin
    nxt = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (sel[k]) begin
        for (int s = 0; s < N_STREAMS; s++) begin
          nxt[s] = lvl_q[k][s] + stride_q[k][s];
        end
      end
    end
  end

  assign hs = offs_valid_o & offs_ready_i;

  always_comb begin
    state_d  = state_q;
    range_d  = range_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    lvl_d    = lvl_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          range_d  = range_i;
          stride_d = stride_i;
          idx_d    = '0;
          for (int k = 0; k < N_LOOPS; k++) begin
            lvl_d[k] = base_i;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (at_end[N_LOOPS-1]) begin
            state_d = DONE;
          end else begin
            for (int k = 0; k < N_LOOPS; k++) begin
              if (sel[k]) begin
                idx_d[k] = idx_q[k] + ONE;
                lvl_d[k] = nxt;
              end else if (at_end[k]) begin
                idx_d[k] = '0;
                lvl_d[k] = nxt;
              end
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d  = IDLE;
      range_d  = '0;
      stride_d = '0;
      idx_d    = '0;
      lvl_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      range_q  <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      lvl_q    <= '0;
    end else begin
      state_q  <= state_d;
      range_q  <= range_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      lvl_q    <= lvl_d;
    end
  end

  // Innermost level base is the current tuple.
  assign offs_o       = lvl_q[0];
  assign offs_valid_o = (state_q == RUN);
  assign loop_end_o   = {N_LOOPS{offs_valid_o}} & at_end;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// tb_mac_loop_ctrl: scoreboard bench for mac_loop_ctrl.
// Directed jobs push expected tuples; a negedge monitor pops and compares.
module tb_mac_loop_ctrl;

  localparam int NL = 3;
  localparam int NS = 3;
  localparam int CW = 12;
  localparam int AW = 32;

  logic clk;
  logic rst_ni;
  logic clear_i;
  logic start_i;
  logic [NL-1:0][CW-1:0] range_i;
  logic [NS-1:0][AW-1:0] base_i;
  logic [NL-1:0][NS-1:0][AW-1:0] stride_i;
  logic [NS-1:0][AW-1:0] offs_o;
  logic offs_valid_o;
  logic offs_ready_i;
  logic [NL-1:0] loop_end_o;
  logic busy_o;
  logic done_o;

  mac_loop_ctrl #(
    .N_LOOPS(NL), .N_STREAMS(NS), .CNT_W(CW), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .start_i(start_i), .range_i(range_i), .base_i(base_i),
    .stride_i(stride_i), .offs_o(offs_o),
    .offs_valid_o(offs_valid_o), .offs_ready_i(offs_ready_i),
    .loop_end_o(loop_end_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0][AW-1:0] offs;
    logic [NL-1:0] le;
    bit last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  bit rnd_rdy = 1'b0;
  bit last_prev = 1'b0;
  bit done_prev = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                      logic [2:0] le, bit last);
    exp_t e;
    e.offs[0] = a;
    e.offs[1] = b;
    e.offs[2] = c;
    e.le = le;
    e.last = last;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_ni || clear_i) begin
      last_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      chk("done_o", 32'(done_o), 32'(last_prev));
      if (done_prev) chk("busy_after_done", 32'(busy_o), 32'd0);
      done_prev = done_o;
      last_prev = 1'b0;
      if (offs_valid_o && !offs_ready_i && sb.size() != 0) begin
        e = sb[0];
        for (int s = 0; s < NS; s++) chk("held_offs", offs_o[s], e.offs[s]);
        chk("held_loop_end", 32'(loop_end_o), 32'(e.le));
      end
      if (offs_valid_o && offs_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tuple act=%h exp=none", offs_o[0]);
        end else begin
          e = sb.pop_front();
          for (int s = 0; s < NS; s++) chk("offs", offs_o[s], e.offs[s]);
          chk("loop_end", 32'(loop_end_o), 32'(e.le));
          last_prev = e.last;
        end
      end
    end
  end

  initial begin
    offs_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      offs_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_start;
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n >= 300), 32'd0);
  endtask

  task automatic cfg_t1;
    range_i = '0;
    range_i[0] = 12'd1;
    range_i[1] = 12'd2;
    base_i = '0;
    base_i[0] = 32'h100;
    base_i[1] = 32'h200;
    base_i[2] = 32'h300;
    stride_i = '0;
    stride_i[0][0] = 32'h4;
    stride_i[0][1] = 32'h1;
    stride_i[1][0] = 32'h40;
    stride_i[1][1] = 32'h10;
    stride_i[1][2] = 32'hFFFF_FFF0;
    stride_i[2][0] = 32'h1000;
  endtask

  task automatic push_t1;
    push(32'h100, 32'h200, 32'h300, 3'b000, 1'b0);
    push(32'h104, 32'h201, 32'h300, 3'b001, 1'b0);
    push(32'h140, 32'h210, 32'h2F0, 3'b000, 1'b0);
    push(32'h144, 32'h211, 32'h2F0, 3'b001, 1'b0);
    push(32'h180, 32'h220, 32'h2E0, 3'b000, 1'b0);
    push(32'h184, 32'h221, 32'h2E0, 3'b111, 1'b1);
  endtask

  task automatic chk_idle_outs(string tag);
    chk({tag, "_valid"}, 32'(offs_valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_loop_end"}, 32'(loop_end_o), 32'd0);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    range_i = '0;
    base_i = '0;
    stride_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset");
    chk("reset_offs", offs_o[0], 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // T1: continuous ready, back-to-back beats
    cfg_t1();
    push_t1();
    do_start();
    repeat (6) @(posedge clk);
    #1;
    chk("t1_done_cycle", 32'(done_o), 32'd1);
    chk("t1_valid_in_done", 32'(offs_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_busy_cleared", 32'(busy_o), 32'd0);
    drain();

    // T2: random ready
    rnd_rdy = 1'b1;
    push_t1();
    do_start();
    drain();
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;

    // T3: single-iteration job
    range_i = '0;
    base_i[0] = 32'h10;
    base_i[1] = 32'h20;
    base_i[2] = 32'h30;
    stride_i = '1;
    push(32'h10, 32'h20, 32'h30, 3'b111, 1'b1);
    do_start();
    drain();

    // T4: clear after beat 3, then restart
    cfg_t1();
    push(32'h100, 32'h200, 32'h300, 3'b000, 1'b0);
    push(32'h104, 32'h201, 32'h300, 3'b001, 1'b0);
    push(32'h140, 32'h210, 32'h2F0, 3'b000, 1'b0);
    do_start();
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_wait_timeout", 32'(n >= 50), 32'd0);
    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    chk_idle_outs("t4_clear");
    chk("t4_clear_offs", offs_o[0], 32'd0);
    push_t1();
    do_start();
    drain();

    // T5: negative stride wraps mod 2^32
    range_i = '0;
    range_i[0] = 12'd2;
    base_i = '0;
    stride_i = '0;
    stride_i[0][0] = 32'hFFFF_FFFC;
    push(32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
    push(32'hFFFF_FFFC, 32'h0, 32'h0, 3'b000, 1'b0);
    push(32'hFFFF_FFF8, 32'h0, 32'h0, 3'b111, 1'b1);
    do_start();
    drain();

    // T6a: start and config changes during RUN are ignored
    cfg_t1();
    push_t1();
    do_start();
    @(posedge clk);
    #1;
    start_i = 1'b1;
    base_i[0] = 32'h999;
    stride_i[0][0] = 32'h8;
    stride_i[1][0] = 32'h80;
    @(posedge clk);
    #1 start_i = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_requeue", 32'(busy_o), 32'd0);

    // T6b: async reset mid-job
    cfg_t1();
    push_t1();
    do_start();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk_idle_outs("t6_rst");
    chk("t6_rst_offs0", offs_o[0], 32'd0);
    chk("t6_rst_offs1", offs_o[1], 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    push_t1();
    do_start();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
